// File: rtl/trigger_period_meter_pkg.sv
// Shared definitions for the trigger period meter: FSM state encoding.
package trigger_period_meter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/trigger_period_meter_rise_detect.sv
// Rising-edge detector for a strobe input: one registered copy of the input
// and a combinational pulse when the input is high now but was low before.
module rise_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic IN,
  output logic PULSE
);

  logic in_d;

  // Delayed copy of the strobe; tracks every cycle regardless of any enable.
  always_ff @(posedge CLK) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation matches the synthesized hardware.
    if (RESET) in_d <= 1'b0;
    else       in_d <= IN;
  end

  assign PULSE = IN & ~in_d;

endmodule

// File: rtl/trigger_period_meter.sv
// Trigger period meter: measures CLK cycles between rising edges of TRIG_IN
// and offers each interval through a single-entry valid/ready slot.
module trigger_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             TRIG_IN,
  output logic             MEAS_VALID,
  input  logic             MEAS_READY,
  output logic [WIDTH-1:0] PERIOD,
  output logic             OVERFLOW,
  output logic             LOCKED,
  output logic             MISSED
);

  import trigger_period_meter_pkg::*;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             trig_event;
  logic             res_valid;
  logic [WIDTH-1:0] res_period;
  logic             res_ovf;
  logic             transfer;

  rise_detect u_rise_detect (
    .CLK   (CLK),
    .RESET (RESET),
    .IN    (TRIG_IN),
    .PULSE (trig_event)
  );

  // Next state, counter update and result generation for the measurement FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    res_valid  = 1'b0;
    res_period = cnt;
    res_ovf    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (ENABLE && trig_event) begin
          state_nxt = ST_RUN;
          cnt_nxt   = WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (!ENABLE) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (trig_event) begin
          // An edge that coincides with cnt==CNT_MAX is still a normal result.
          res_valid = 1'b1;
          cnt_nxt   = WIDTH'(1);
        end else if (cnt == CNT_MAX) begin
          res_valid  = 1'b1;
          res_period = CNT_MAX;
          res_ovf    = 1'b1;
          state_nxt  = ST_IDLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and interval counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign transfer = MEAS_VALID & MEAS_READY;

  // One-entry output slot; a result arriving with a transfer refills it without
  // a bubble, a result arriving while it is full and stalled is dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEAS_VALID <= 1'b0;
      PERIOD     <= '0;
      OVERFLOW   <= 1'b0;
      MISSED     <= 1'b0;
    end else if (res_valid) begin
      if (!MEAS_VALID || transfer) begin
        MEAS_VALID <= 1'b1;
        PERIOD     <= res_period;
        OVERFLOW   <= res_ovf;
      end else begin
        MISSED <= 1'b1;
      end
    end else if (transfer) begin
      MEAS_VALID <= 1'b0;
    end
  end

  assign LOCKED = (state == ST_RUN);

endmodule

// File: tb/tb_trigger_period_meter.sv
// Bench for trigger_period_meter: a 16-bit and a 4-bit instance share the same
// stimulus and are compared every cycle against a time-stamp based model.
module tb_trigger_period_meter;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, TRIG_IN, MEAS_READY;
  logic        v16, o16, l16, ms16;
  logic [15:0] p16;
  logic        v4, o4, l4, ms4;
  logic [3:0]  p4;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;

  trigger_period_meter #(.WIDTH(16)) dut16 (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .TRIG_IN(TRIG_IN),
    .MEAS_VALID(v16), .MEAS_READY(MEAS_READY), .PERIOD(p16),
    .OVERFLOW(o16), .LOCKED(l16), .MISSED(ms16)
  );

  trigger_period_meter #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .TRIG_IN(TRIG_IN),
    .MEAS_VALID(v4), .MEAS_READY(MEAS_READY), .PERIOD(p4),
    .OVERFLOW(o4), .LOCKED(l4), .MISSED(ms4)
  );

  // Model: remembers the cycle of the reference edge instead of counting.
  typedef struct {
    bit locked;
    int t_ref;
    bit valid;
    int period;
    bit ovf;
    bit missed;
    bit trig_prev;
  } model_t;

  model_t m16, m4;

  function automatic model_t model_next(model_t m, bit rst, bit en, bit trig,
                                        bit rdy, int cnt_max, int t);
    model_t n;
    bit     ev, prod, o, xfer;
    int     p;
    n    = m;
    ev   = trig && !m.trig_prev;
    xfer = m.valid && rdy;
    prod = 0;
    p    = 0;
    o    = 0;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    n.trig_prev = trig;
    if (!m.locked) begin
      if (en && ev) begin
        n.locked = 1;
        n.t_ref  = t;
      end
    end else if (!en) begin
      n.locked = 0;
    end else if (ev) begin
      prod    = 1;
      p       = t - m.t_ref;
      n.t_ref = t;
    end else if (t - m.t_ref == cnt_max) begin
      prod     = 1;
      p        = cnt_max;
      o        = 1;
      n.locked = 0;
    end
    if (prod) begin
      if (!m.valid || xfer) begin
        n.valid  = 1;
        n.period = p;
        n.ovf    = o;
      end else begin
        n.missed = 1;
      end
    end else if (xfer) begin
      n.valid = 0;
    end
    return n;
  endfunction

  // PERIOD/OVERFLOW only carry meaning while the slot is valid.
  function automatic bit differs(model_t m, bit v, int p, bit o, bit l, bit ms);
    if (v !== m.valid || l !== m.locked || ms !== m.missed) return 1;
    if (m.valid && (p != m.period || o !== m.ovf)) return 1;
    return 0;
  endfunction

  function automatic string show(model_t m, bit v, int p, bit o, bit l, bit ms);
    return $sformatf("got v=%b p=%0d ovf=%b lk=%b ms=%b, expected v=%b p=%0d ovf=%b lk=%b ms=%b",
                     v, p, o, l, ms, m.valid, m.period, m.ovf, m.locked, m.missed);
  endfunction

  // Advance one clock; the model consumes the inputs the DUT sampled.
  task automatic tick();
    @(posedge CLK);
    m16 = model_next(m16, RESET, ENABLE, TRIG_IN, MEAS_READY, 65535, cyc);
    m4  = model_next(m4,  RESET, ENABLE, TRIG_IN, MEAS_READY, 15,    cyc);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1; ENABLE = 0; TRIG_IN = 0; MEAS_READY = 1;
    tick(); tick();
    checks++;
    if ({v16, p16, o16, l16, ms16} !== 20'd0 || {v4, p4, o4, l4, ms4} !== 8'd0) begin
      errors++;
      $display("FAIL reset: w16 %b w4 %b, expected all zero", {v16, p16, o16, l16, ms16},
               {v4, p4, o4, l4, ms4});
    end
    RESET = 0;
  endtask

  task automatic test_idle_no_trigger();
    ENABLE = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (l16 !== 1'b0 || v16 !== 1'b0 || l4 !== 1'b0 || v4 !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc%0d: lk=%b/%b v=%b/%b, expected 0", cyc, l16, l4, v16, v4);
      end
    end
  endtask

  task automatic test_periodic();
    int nres = 0;
    MEAS_READY = 1;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 5; k++) begin
        TRIG_IN = (k == 0);
        tick();
        checks++;
        if (differs(m16, v16, p16, o16, l16, ms16) || differs(m4, v4, p4, o4, l4, ms4)) begin
          errors++;
          $display("FAIL periodic cyc%0d: %s", cyc, show(m16, v16, p16, o16, l16, ms16));
        end
        if (v16) begin
          nres++;
          checks++;
          if (p16 !== 16'd5 || o16 !== 1'b0) begin
            errors++;
            $display("FAIL periodic_value: period=%0d ovf=%b, expected 5/0", p16, o16);
          end
        end
      end
    end
    checks++;
    if (nres != 5) begin
      errors++;
      $display("FAIL periodic_count: results=%0d, expected 5", nres);
    end
  endtask

  task automatic test_timeout();
    RESET = 1; TRIG_IN = 0; tick(); RESET = 0;
    TRIG_IN = 1; tick(); TRIG_IN = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (differs(m16, v16, p16, o16, l16, ms16) || differs(m4, v4, p4, o4, l4, ms4)) begin
        errors++;
        $display("FAIL timeout cyc%0d: %s", cyc, show(m4, v4, p4, o4, l4, ms4));
      end
      if (i == 15) begin
        checks++;
        if (v4 !== 1'b1 || p4 !== 4'd15 || o4 !== 1'b1 || l4 !== 1'b0 || l16 !== 1'b1) begin
          errors++;
          $display("FAIL timeout_result: v=%b p=%0d ovf=%b lk4=%b lk16=%b, expected 1 15 1 0 1",
                   v4, p4, o4, l4, l16);
        end
      end
    end
    TRIG_IN = 1; tick(); TRIG_IN = 0;
    checks++;
    if (l4 !== 1'b1 || v4 !== 1'b0 || v16 !== 1'b1 || p16 !== 16'd21) begin
      errors++;
      $display("FAIL relock: lk4=%b v4=%b v16=%b p16=%0d, expected 1 0 1 21", l4, v4, v16, p16);
    end
  endtask

  task automatic test_backpressure();
    RESET = 1; TRIG_IN = 0; tick(); RESET = 0;
    MEAS_READY = 0;
    for (int e = 0; e < 3; e++) begin
      for (int k = 0; k < 4; k++) begin
        TRIG_IN = (k == 0);
        tick();
      end
    end
    TRIG_IN = 0;
    checks++;
    if (v16 !== 1'b1 || p16 !== 16'd4 || ms16 !== 1'b1 || ms4 !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_hold: v=%b p=%0d ms=%b/%b, expected 1 4 1/1", v16, p16, ms16, ms4);
    end
    MEAS_READY = 1;
    tick();
    checks++;
    if (v16 !== 1'b0 || differs(m16, v16, p16, o16, l16, ms16) || differs(m4, v4, p4, o4, l4, ms4)) begin
      errors++;
      $display("FAIL backpressure_drain: %s", show(m16, v16, p16, o16, l16, ms16));
    end
  endtask

  task automatic test_back_to_back();
    RESET = 1; TRIG_IN = 0; tick(); RESET = 0;
    MEAS_READY = 0;
    TRIG_IN = 1; tick(); TRIG_IN = 0;
    repeat (4) tick();
    TRIG_IN = 1; tick(); TRIG_IN = 0;
    checks++;
    if (v16 !== 1'b1 || p16 !== 16'd5) begin
      errors++;
      $display("FAIL b2b_first: v=%b p=%0d, expected 1 5", v16, p16);
    end
    repeat (6) tick();
    TRIG_IN = 1; MEAS_READY = 1; tick(); TRIG_IN = 0; MEAS_READY = 0;
    checks++;
    if (v16 !== 1'b1 || p16 !== 16'd7 || ms16 !== 1'b0 || differs(m4, v4, p4, o4, l4, ms4)) begin
      errors++;
      $display("FAIL b2b_refill: v=%b p=%0d ms=%b, expected 1 7 0", v16, p16, ms16);
    end
  endtask

  task automatic test_long_pulse_enable();
    RESET = 1; TRIG_IN = 0; tick(); RESET = 0;
    MEAS_READY = 1;
    for (int e = 0; e < 5; e++) begin
      for (int k = 0; k < 8; k++) begin
        TRIG_IN = (k < 3);
        tick();
        checks++;
        if (differs(m16, v16, p16, o16, l16, ms16) || (v16 && p16 !== 16'd8)) begin
          errors++;
          $display("FAIL long_pulse cyc%0d: %s", cyc, show(m16, v16, p16, o16, l16, ms16));
        end
      end
    end
    TRIG_IN = 1; tick(); TRIG_IN = 0;
    repeat (3) tick();
    ENABLE = 0; tick();
    checks++;
    if (l16 !== 1'b0 || l4 !== 1'b0) begin
      errors++;
      $display("FAIL disable_unlock: lk=%b/%b, expected 0/0", l16, l4);
    end
    TRIG_IN = 1; tick(); ENABLE = 1; tick(); tick();
    checks++;
    if (l16 !== 1'b0 || v16 !== 1'b0 || differs(m4, v4, p4, o4, l4, ms4)) begin
      errors++;
      $display("FAIL enable_high_trig: lk=%b v=%b, expected 0 0", l16, v16);
    end
    TRIG_IN = 0; tick(); TRIG_IN = 1; tick(); TRIG_IN = 0; tick();
    RESET = 1; tick(); RESET = 0;
    checks++;
    if ({v16, p16, o16, l16, ms16} !== 20'd0 || {v4, p4, o4, l4, ms4} !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_run: w16 %b w4 %b, expected all zero", {v16, p16, o16, l16, ms16},
               {v4, p4, o4, l4, ms4});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      TRIG_IN    = ($urandom_range(0, 5) == 0);
      MEAS_READY = ($urandom_range(0, 3) != 0);
      ENABLE     = ($urandom_range(0, 60) != 0);
      RESET      = ($urandom_range(0, 400) == 0);
      tick();
      checks++;
      if (differs(m16, v16, p16, o16, l16, ms16) || differs(m4, v4, p4, o4, l4, ms4)) begin
        errors++;
        $display("FAIL random cyc%0d: w16 %s | w4 %s", cyc, show(m16, v16, p16, o16, l16, ms16),
                 show(m4, v4, p4, o4, l4, ms4));
      end
    end
    RESET = 0;
  endtask

  initial begin
    m16 = '{default: 0};
    m4  = '{default: 0};
    test_reset();
    test_idle_no_trigger();
    test_periodic();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_long_pulse_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
